// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers stereo PCM pairs in a small FIFO and shifts them
// out MSB-first on codec DIN, timed by oversampled codec-mastered sclk/lrclk.
module i2s_tx_serializer #(
   parameter int DATA_W     = 16,
   parameter int SLOT_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          en,
   input  logic                          mute,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_left,
   input  logic [DATA_W-1:0]             s_right,
   input  logic                          sclk,
   input  logic                          lrclk,
   output logic                          dout,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          underrun,
   input  logic                          underrun_clr
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = $clog2(DATA_W + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] BIT_DONE = BIT_W'(DATA_W);

   // The word plus its one-bit I2S delay must fit inside a slot.
   if (DATA_W > SLOT_W - 1) begin : g_bad_slot_w
      $error("i2s_tx_serializer: DATA_W must be <= SLOT_W-1");
   end
   if ((FIFO_DEPTH < 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("i2s_tx_serializer: FIFO_DEPTH must be a power of 2");
   end

   // ------------------------------------------------------------------
   // sclk / lrclk synchronizers
   // ------------------------------------------------------------------
   logic sclk_meta, sclk_sync, sclk_hist;
   logic lr_meta, lr_sync;
   logic fall_evt;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_meta <= 1'b0;
         sclk_sync <= 1'b0;
         sclk_hist <= 1'b0;
         lr_meta   <= 1'b0;
         lr_sync   <= 1'b0;
      end else begin
         sclk_meta <= sclk;
         sclk_sync <= sclk_meta;
         sclk_hist <= sclk_sync;
         lr_meta   <= lrclk;
         lr_sync   <= lr_meta;
      end
   end

   assign fall_evt = sclk_hist & ~sclk_sync;

   // ------------------------------------------------------------------
   // Slot detection: lrclk is compared only at sclk falling edges
   // ------------------------------------------------------------------
   logic lr_prev;
   logic left_start, right_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lr_prev <= 1'b0;
      end else if (fall_evt) begin
         lr_prev <= lr_sync;
      end
   end

   assign left_start  = fall_evt &  lr_prev & ~lr_sync;
   assign right_start = fall_evt & ~lr_prev &  lr_sync;

   // ------------------------------------------------------------------
   // Pair FIFO
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              fifo_empty;
   logic              push, pop;
   logic              underrun_set;

   assign fifo_empty   = (count == '0);
   assign s_ready      = (count < CNT_FULL);
   assign fill_level   = count;
   assign push         = s_valid & s_ready;
   // Emptiness is the registered count, so a same-cycle push cannot rescue a pop.
   assign pop          = left_start & en & ~fifo_empty;
   assign underrun_set = left_start & en &  fifo_empty;

   // NOTE: the storage array carries no reset; only the pointers and count
   // define what is valid, which keeps the array as plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_l[wr_ptr] <= s_left;
         mem_r[wr_ptr] <= s_right;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun <= 1'b0;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end else if (underrun_set) begin
         underrun <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Serializer
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] load_l, load_r;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic              active;

   // NOTE: every output of this block is assigned on all paths, so no latch
   // can be inferred for the muxed load values.
   always_comb begin
      load_l = '0;
      load_r = '0;
      if (!fifo_empty && !mute) begin
         load_l = mem_l[rd_ptr];
         load_r = mem_r[rd_ptr];
      end
   end

   // A frame only becomes active at a left start with en high; a right start
   // seen first while inactive is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active  <= 1'b0;
         hold_l  <= '0;
         hold_r  <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         dout    <= 1'b0;
      end else if (!en) begin
         active <= 1'b0;
         dout   <= 1'b0;
      end else if (left_start) begin
         active  <= 1'b1;
         hold_l  <= load_l;
         hold_r  <= load_r;
         shreg   <= load_l;
         bit_cnt <= '0;
         dout    <= 1'b0;
      end else if (fall_evt && active) begin
         if (right_start) begin
            shreg   <= hold_r;
            bit_cnt <= '0;
            dout    <= 1'b0;
         end else if (bit_cnt < BIT_DONE) begin
            dout    <= shreg[DATA_W-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
         end else begin
            dout <= 1'b0;
         end
      end
   end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Consumes stereo PCM pairs from the audio SoC datapath through a valid/ready port, buffers them in a small FIFO, and serializes them onto the codec DAC data line in standard I2S format.
- The SGTL5000 is clock master: sclk and lrclk are board inputs, asynchronous to the 50 MHz system clock, and are oversampled.
- Output feeds the pin that drives codec DIN. Nominal rates: sclk = 64·fs ≈ 3.125 MHz, with 12.5 MHz MCLK.

Parameters:
- DATA_W, 16: PCM sample width per channel, two's complement.
- SLOT_W, 32: sclk periods per channel slot. Must satisfy DATA_W ≤ SLOT_W−1.
- FIFO_DEPTH, 4: number of stereo pairs buffered. Must be a power of 2.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  transmit enable.
- mute  in  1  transmit zeros while still consuming samples.
- s_valid  in  1  input pair valid.
- s_ready  out  1  FIFO can accept a pair.
- s_left  in  DATA_W  left sample.
- s_right  in  DATA_W  right sample.
- sclk  in  1  codec bit clock, asynchronous.
- lrclk  in  1  codec word clock, asynchronous. 0 = left channel.
- dout  out  1  serial data to codec DIN.
- fill_level  out  log2(FIFO_DEPTH)+1  pairs currently in the FIFO.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- underrun_clr  in  1  clears underrun.

Behaviour:
- **Reset** (asynchronous assert, synchronous to clk on release):
  - dout=0, s_ready=1, fill_level=0, underrun=0.
  - FIFO empty, shift register 0, bit counter 0, holding registers 0.
  - Synchronizer flops are reset to 0.
  - Reset asserted mid-frame aborts the frame immediately. After release, transmission resumes at the next left-slot start.
- **Input sync:** sclk and lrclk each pass through a 2-flop synchronizer plus one history flop.
  - fall_evt = synced sclk 1→0.
  - Only fall_evt advances serialization. Rising edges are ignored.
- **FIFO:**
  - Push when s_valid && s_ready; s_ready = (fill_level < FIFO_DEPTH).
  - Pop happens internally at left-slot start.
  - Simultaneous push and pop in one cycle: fill_level unchanged.
  - Push into an empty FIFO in the same cycle as a pop attempt: the pop sees empty (underrun), and the pushed pair remains.
  - Pointers wrap modulo FIFO_DEPTH.
- **Slot detection:**
  - On each fall_evt, compare synced lrclk with lr_prev (lrclk captured at the previous fall_evt), then update lr_prev.
  - A difference means a slot start.
  - lrclk 1→0 = left start; lrclk 0→1 = right start.
- **Left start** (en=1):
  - FIFO non-empty: pop a pair into hold_L and hold_R.
  - FIFO empty: hold_L = hold_R = 0 and set underrun.
  - If mute=1, the loaded values are forced to 0, but the pop still occurs.
  - Shift register ← hold_L; bit_cnt ← 0.
  - dout on this same fall_evt = 0 (last padding bit of the previous slot).
- **Right start:** shift register ← hold_R (zero if muted at the preceding left start); bit_cnt ← 0.
- **Subsequent fall_evt within a slot:**
  - While bit_cnt < DATA_W: dout ← shreg[DATA_W−1], shreg shifts left by 1, bit_cnt++.
  - After that: dout ← 0 for the remainder of the slot. bit_cnt saturates at DATA_W.
  - This gives the I2S one-bit delay: MSB on the first falling edge after the lrclk transition, MSB-first order.
- **Latency:** dout updates 3 clk cycles after the physical sclk falling edge. This is well within the 8-cycle sclk low phase, so the codec samples it on the rising edge.
- **en=0:**
  - dout held 0, no pops, underrun not set.
  - FIFO still accepts pushes.
  - en rising takes effect only at the next left start; a right start seen first is ignored (dout stays 0).
- **underrun flag:** underrun_clr has priority over a simultaneous set. The clear takes effect one clk later; if underrun_clr and a set occur in the same cycle, underrun=0.
- **Malformed slot:** a slot shorter than DATA_W bits (lrclk toggles early) truncates the current word and starts the new slot normally; no error is raised.

Test Plan:
- Push (L=0xA5C3, R=0x0F0F), en=1, run a 64·fs stimulus → left slot dout = 0 followed by 1010010111000011, then 15 zeros; right slot = 0 followed by 0000111100001111, then zeros. fill_level goes 1→0 at the left start.
- FIFO fill: push 5 pairs back-to-back with no sclk → s_ready falls after the 4th pair, the 5th is held; fill_level=4. After one left start, fill_level=3, s_ready=1, and the 5th pair is accepted.
- Underrun: en=1 with the FIFO empty for 2 frames → dout all 0, underrun=1. Pulse underrun_clr → underrun=0. Assert underrun_clr in the same cycle as an empty left start → underrun stays 0.
- Mute: push 0x7FFF/0x8000 with mute=1 → dout all zeros for the whole frame, fill_level decrements by 1.
- Enable mid-frame: assert en during a right slot → dout remains 0 until the next lrclk 1→0; the first serialized word is the left sample of the head FIFO pair.
- Reset mid-word: assert reset_n=0 after 7 bits of the left slot → dout=0 immediately, fill_level=0, underrun=0. After release, the next left start with pushed 0x8001 serializes as 1000000000000001.
